muldiv_unit: RTL

Iterative multiply/divide unit for the RV32M extension, placed in the execute stage beside the combinational ALU. It consumes the decoded `funct3` and the two EX-stage operands, then runs a fixed-latency shift-add multiply or restoring divide. While it works it holds `busy` so the hazard unit can stall IF/ID/EX. It produces one result with a single-cycle `done` pulse for the EX/MEM register.

---
 rtl/muldiv_unit.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
`timescale 1ns/1ps
// muldiv_unit: iterative RV32M multiply/divide beside the EX-stage ALU.
// Shift-add multiply, restoring divide, fixed XLEN-cycle latency.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2:0]        op;
  logic              sa;
  logic              sb;
  logic              div0;
  logic [XLEN-1:0]   opnd;
  logic [2*XLEN-1:0] prod;

  logic              sa_in;
  logic              sb_in;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     shl;
  logic [XLEN:0]     diff;
  logic [2*XLEN-1:0] nxt;
  logic [2*XLEN-1:0] mul_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   res_nxt;

  // Operand sign decode and magnitudes for the incoming request
  always_comb begin
    sa_in = 1'b0;
    sb_in = 1'b0;
    if (funct3[2]) begin
      sa_in = ~funct3[0] & src_a[XLEN-1];
      sb_in = ~funct3[0] & src_b[XLEN-1];
    end else begin
      sa_in = (funct3[1:0] != 2'b11) & src_a[XLEN-1];
      sb_in = ~funct3[1] & src_b[XLEN-1];
    end
    a_mag = sa_in ? -src_a : src_a;
    b_mag = sb_in ? -src_b : src_b;
  end

  // One iteration step plus the sign fix-up applied on the last one.
  // prod holds {acc, multiplier} for MUL and {rem, quo} for DIV.
  always_comb begin
    mul_sum = {1'b0, prod[2*XLEN-1:XLEN]}
            + (prod[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    shl     = {prod[2*XLEN-1:XLEN], prod[XLEN-1]};
    diff    = shl - {1'b0, opnd};
    nxt     = '0;
    if (!op[2])
      nxt = {mul_sum, prod[XLEN-1:1]};
    else if (diff[XLEN])
      nxt = {shl[XLEN-1:0], prod[XLEN-2:0], 1'b0};
    else
      nxt = {diff[XLEN-1:0], prod[XLEN-2:0], 1'b1};

    mul_fix = (sa ^ sb) ? -nxt : nxt;
    quo_fix = div0 ? '1
            : ((sa ^ sb) ? -nxt[XLEN-1:0] : nxt[XLEN-1:0]);
    rem_fix = sa ? -nxt[2*XLEN-1:XLEN] : nxt[2*XLEN-1:XLEN];

    res_nxt = '0;
    unique case (1'b1)
      (!op[2] && op[1:0] == 2'b00): res_nxt = mul_fix[XLEN-1:0];
      (!op[2] && op[1:0] != 2'b00): res_nxt = mul_fix[2*XLEN-1:XLEN];
      (op[2] && !op[1]):            res_nxt = quo_fix;
      (op[2] && op[1]):             res_nxt = rem_fix;
      default:                      res_nxt = '0;
    endcase
  end

  // Control FSM with registered busy/done/result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      op     <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      div0   <= 1'b0;
      opnd   <= '0;
      prod   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else if (flush) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            op    <= funct3;
            sa    <= sa_in;
            sb    <= sb_in;
            div0  <= (src_b == '0);
            opnd  <= funct3[2] ? b_mag : a_mag;
            prod  <= funct3[2] ? {{XLEN{1'b0}}, a_mag}
                               : {{XLEN{1'b0}}, b_mag};
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          prod <= nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            result <= res_nxt;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
